// File: rtl/aes_frame_loader_pkg.sv
// Shared constants and FSM state type for the AES frame loader.
package aes_frame_pkg;

  localparam logic [7:0]  HDR_DEFAULT = 8'hA5;
  localparam logic [7:0]  TYPE_MSG    = 8'h00;
  localparam logic [7:0]  TYPE_KEYMSG = 8'h01;
  localparam int unsigned BLK_BYTES   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TYPE,
    ST_KEY,
    ST_MSG,
    ST_CSUM,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/aes_frame_loader_if.sv
// Byte-stream input, committed block output and error pulses of the frame loader.
interface aes_frame_loader_if;

  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic [127:0] msg_out;
  logic [127:0] key_out;
  logic         out_valid;
  logic         out_ready;
  logic         key_loaded;
  logic         err_csum;
  logic         err_frame;
  logic         err_timeout;

  modport slave (
    input  byte_in, byte_valid, out_ready,
    output byte_ready, msg_out, key_out, out_valid, key_loaded,
           err_csum, err_frame, err_timeout
  );

  modport master (
    output byte_in, byte_valid, out_ready,
    input  byte_ready, msg_out, key_out, out_valid, key_loaded,
           err_csum, err_frame, err_timeout
  );

endinterface

// File: rtl/aes_frame_loader_timer.sv
// Inter-byte idle counter; expire is asserted while the count sits at TIMEOUT_CYC.
module frame_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

  logic [W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                        cnt_d = '0;
    else if (enable && cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
  end

  // A byte accepted in the expiry cycle wins over the timeout.
  assign expire = enable && !clear && (cnt_q == LIMIT);

endmodule

// File: rtl/aes_frame_loader.sv
// Parses HDR/TYPE/payload/CSUM byte frames into a 128-bit message and key for the AES wrapper.
module aes_frame_loader
  import aes_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0]  HDR_BYTE    = HDR_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  aes_frame_loader_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'(BLK_BYTES - 1);

  state_t       state_q, state_d;
  logic [127:0] msg_sh_q, msg_sh_d;
  logic [127:0] key_sh_q, key_sh_d;
  logic [127:0] msg_q, msg_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   acc_q, acc_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         is_key_q, is_key_d;
  logic         key_loaded_q, key_loaded_d;
  logic         err_csum_q, err_csum_d;
  logic         err_frame_q, err_frame_d;
  logic         err_timeout_q, err_timeout_d;

  logic ready, byte_acc, in_frame, tmr_clear, tmr_expire;

  assign ready     = !rst && (state_q != ST_HOLD);
  assign byte_acc  = bus.byte_valid && ready;
  assign in_frame  = (state_q == ST_TYPE) || (state_q == ST_KEY) ||
                     (state_q == ST_MSG)  || (state_q == ST_CSUM);
  assign tmr_clear = byte_acc || !in_frame;

  frame_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (in_frame),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      msg_sh_q      <= '0;
      key_sh_q      <= '0;
      msg_q         <= '0;
      key_q         <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      is_key_q      <= 1'b0;
      key_loaded_q  <= 1'b0;
      err_csum_q    <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      msg_sh_q      <= msg_sh_d;
      key_sh_q      <= key_sh_d;
      msg_q         <= msg_d;
      key_q         <= key_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      is_key_q      <= is_key_d;
      key_loaded_q  <= key_loaded_d;
      err_csum_q    <= err_csum_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    msg_sh_d      = msg_sh_q;
    key_sh_d      = key_sh_q;
    msg_d         = msg_q;
    key_d         = key_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    is_key_d      = is_key_q;
    key_loaded_d  = key_loaded_q;
    err_csum_d    = 1'b0;
    err_frame_d   = 1'b0;
    err_timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (byte_acc && bus.byte_in == HDR_BYTE) begin
          state_d  = ST_TYPE;
          msg_sh_d = '0;
          key_sh_d = '0;
        end
      end
      ST_TYPE: begin
        if (byte_acc) begin
          cnt_d = '0;
          acc_d = bus.byte_in;
          if (bus.byte_in == TYPE_MSG) begin
            is_key_d = 1'b0;
            state_d  = ST_MSG;
          end else if (bus.byte_in == TYPE_KEYMSG) begin
            is_key_d = 1'b1;
            state_d  = ST_KEY;
          end else begin
            err_frame_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_KEY: begin
        if (byte_acc) begin
          key_sh_d = {key_sh_q[119:0], bus.byte_in};
          acc_d    = acc_q ^ bus.byte_in;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = ST_MSG;
        end
      end
      ST_MSG: begin
        if (byte_acc) begin
          msg_sh_d = {msg_sh_q[119:0], bus.byte_in};
          acc_d    = acc_q ^ bus.byte_in;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (byte_acc) begin
          if (bus.byte_in == acc_q) begin
            msg_d   = msg_sh_q;
            state_d = ST_HOLD;
            if (is_key_q) begin
              key_d        = key_sh_q;
              key_loaded_d = 1'b1;
            end
          end else begin
            err_csum_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmr_expire) begin
      err_timeout_d = 1'b1;
      state_d       = ST_IDLE;
    end
  end

  always_comb begin
    bus.byte_ready  = ready;
    bus.out_valid   = (state_q == ST_HOLD);
    bus.msg_out     = msg_q;
    bus.key_out     = key_q;
    bus.key_loaded  = key_loaded_q;
    bus.err_csum    = err_csum_q;
    bus.err_frame   = err_frame_q;
    bus.err_timeout = err_timeout_q;
  end

endmodule

// File: tb/tb_aes_frame_loader.sv
// Self-checking bench for aes_frame_loader: directed vector table, corner sequences, random frames.
module tb_aes_frame_loader;

  localparam int unsigned TMO = 16;
  localparam logic [7:0]  HDR = 8'hA5;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] M1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] M5A = {16{8'h5A}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_frame_loader_if bi();

  aes_frame_loader #(.TIMEOUT_CYC(TMO), .HDR_BYTE(HDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bi)
  );

  typedef struct {
    logic [7:0]   typ;
    logic [127:0] key;
    logic [127:0] msg;
    logic [7:0]   cx;
    logic         exp_valid;
    logic         exp_csum;
    logic         exp_frame;
    logic [127:0] exp_msg;
    logic [127:0] exp_key;
    logic         exp_kl;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int n_csum = 0, n_frame = 0, n_tmo = 0;

  logic [127:0] exp_msg, exp_key;
  logic         exp_kl;

  always @(negedge clk) begin
    if (bi.err_csum)    n_csum++;
    if (bi.err_frame)   n_frame++;
    if (bi.err_timeout) n_tmo++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned w;
    @(negedge clk);
    bi.byte_in    = b;
    bi.byte_valid = 1'b1;
    w = 0;
    while (!bi.byte_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bi.byte_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_ready_wait: got 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1 bi.byte_valid = 1'b0;
  endtask

  // Frame built from the protocol rules: HDR, TYPE, payload (key then msg), XOR checksum.
  task automatic send_frame(input logic [7:0] typ, input logic [127:0] key, input logic [127:0] msg,
                            input logic [7:0] cx, input int unsigned gap);
    logic [7:0] q[$];
    logic [7:0] cs;
    q.push_back(HDR);
    q.push_back(typ);
    if (typ == 8'h01)
      for (int i = 0; i < 16; i++) q.push_back(key[127 - 8*i -: 8]);
    if (typ == 8'h00 || typ == 8'h01) begin
      for (int i = 0; i < 16; i++) q.push_back(msg[127 - 8*i -: 8]);
      cs = 8'h00;
      for (int i = 1; i < q.size(); i++) cs = cs ^ q[i];
      q.push_back(cs ^ cx);
    end
    for (int i = 0; i < q.size(); i++) begin
      if (i != 0 && gap != 0) repeat ($urandom_range(gap, 0)) @(negedge clk);
      send_byte(q[i]);
    end
  endtask

  // Reference outcome of one frame; returns 1 when the frame should commit.
  function automatic logic model(input logic [7:0] typ, input logic [127:0] key,
                                 input logic [127:0] msg, input logic [7:0] cx);
    if (typ > 8'h01 || cx != 8'h00) return 1'b0;
    exp_msg = msg;
    if (typ == 8'h01) begin
      exp_key = key;
      exp_kl  = 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic frame_and_check(input string nm, input logic [7:0] typ, input logic [127:0] key,
                                 input logic [127:0] msg, input logic [7:0] cx, input int unsigned gap,
                                 input logic e_valid, input logic e_csum, input logic e_frame,
                                 input logic [127:0] e_msg, input logic [127:0] e_key, input logic e_kl);
    int c0, f0, t0;
    c0 = n_csum; f0 = n_frame; t0 = n_tmo;
    send_frame(typ, key, msg, cx, gap);
    @(negedge clk);
    check({nm, ".out_valid"}, bi.out_valid, e_valid);
    check({nm, ".msg_out"}, bi.msg_out, e_msg);
    check({nm, ".key_out"}, bi.key_out, e_key);
    check({nm, ".key_loaded"}, bi.key_loaded, e_kl);
    repeat (3) @(posedge clk);
    #1;
    check({nm, ".err_csum_pulses"}, 128'(n_csum - c0), 128'(e_csum));
    check({nm, ".err_frame_pulses"}, 128'(n_frame - f0), 128'(e_frame));
    check({nm, ".err_timeout_pulses"}, 128'(n_tmo - t0), 128'd0);
  endtask

  initial begin
    vec_t tbl[4];
    logic [127:0] r_msg, r_key;
    logic [7:0]   r_typ, r_cx, junk;
    logic         e_valid;
    int unsigned  k, hold_n, kind;
    int           t0;

    tbl[0] = '{typ:8'h01, key:K1, msg:M1, cx:8'h00, exp_valid:1'b1, exp_csum:1'b0, exp_frame:1'b0,
               exp_msg:M1, exp_key:K1, exp_kl:1'b1};
    tbl[1] = '{typ:8'h00, key:'0, msg:M5A, cx:8'h00, exp_valid:1'b1, exp_csum:1'b0, exp_frame:1'b0,
               exp_msg:M5A, exp_key:K1, exp_kl:1'b1};
    tbl[2] = '{typ:8'h01, key:128'hffeeddccbbaa99887766554433221100, msg:128'h0123456789abcdef0123456789abcdef,
               cx:8'h01, exp_valid:1'b0, exp_csum:1'b1, exp_frame:1'b0, exp_msg:M5A, exp_key:K1, exp_kl:1'b1};
    tbl[3] = '{typ:8'h07, key:'0, msg:'0, cx:8'h00, exp_valid:1'b0, exp_csum:1'b0, exp_frame:1'b1,
               exp_msg:M5A, exp_key:K1, exp_kl:1'b1};

    rst = 1'b1;
    bi.byte_in = '0;
    bi.byte_valid = 1'b0;
    bi.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.byte_ready", bi.byte_ready, 1'b0);
    check("rst.out_valid", bi.out_valid, 1'b0);
    check("rst.msg_out", bi.msg_out, '0);
    check("rst.key_out", bi.key_out, '0);
    check("rst.key_loaded", bi.key_loaded, 1'b0);
    check("rst.errs", {bi.err_csum, bi.err_frame, bi.err_timeout}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.byte_ready", bi.byte_ready, 1'b1);

    for (int i = 0; i < 4; i++)
      frame_and_check($sformatf("tbl%0d", i), tbl[i].typ, tbl[i].key, tbl[i].msg, tbl[i].cx, 2,
                      tbl[i].exp_valid, tbl[i].exp_csum, tbl[i].exp_frame,
                      tbl[i].exp_msg, tbl[i].exp_key, tbl[i].exp_kl);
    exp_msg = M5A;
    exp_key = K1;
    exp_kl  = 1'b1;

    // Output held while downstream stalls.
    bi.out_ready = 1'b0;
    send_frame(8'h01, K1, M1, 8'h00, 1);
    void'(model(8'h01, K1, M1, 8'h00));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold.out_valid", bi.out_valid, 1'b1);
      check("hold.msg_out", bi.msg_out, exp_msg);
      check("hold.key_out", bi.key_out, exp_key);
      check("hold.byte_ready", bi.byte_ready, 1'b0);
    end
    bi.out_ready = 1'b1;
    @(negedge clk);
    check("release.out_valid", bi.out_valid, 1'b0);
    check("release.byte_ready", bi.byte_ready, 1'b1);

    // Inter-byte timeout after 8 message bytes.
    t0 = n_tmo;
    send_byte(HDR);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 8'h30));
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (bi.err_timeout) break;
    end
    vectors++;
    if (k < TMO + 1 || k > TMO + 2) begin
      miscompares++;
      $display("FAIL timeout.delay: got %0d cycles expected %0d..%0d", k, TMO + 1, TMO + 2);
    end
    repeat (3) @(posedge clk);
    #1;
    check("timeout.pulses", 128'(n_tmo - t0), 128'd1);
    check("timeout.msg_out", bi.msg_out, exp_msg);
    r_msg = {$urandom, $urandom, $urandom, $urandom};
    e_valid = model(8'h00, '0, r_msg, 8'h00);
    frame_and_check("after_timeout", 8'h00, '0, r_msg, 8'h00, 2, e_valid, 1'b0, 1'b0, exp_msg, exp_key, exp_kl);

    // Reset in the middle of a message payload.
    send_byte(HDR);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(8'hC0);
    @(negedge clk);
    bi.byte_in = 8'hC0;
    bi.byte_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst.byte_ready", bi.byte_ready, 1'b0);
    check("midrst.out_valid", bi.out_valid, 1'b0);
    check("midrst.msg_out", bi.msg_out, '0);
    check("midrst.key_out", bi.key_out, '0);
    check("midrst.key_loaded", bi.key_loaded, 1'b0);
    rst = 1'b0;
    bi.byte_valid = 1'b0;
    @(negedge clk);
    check("midrst.byte_ready_after", bi.byte_ready, 1'b1);
    exp_msg = '0;
    exp_key = '0;
    exp_kl  = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    r_msg = {$urandom, $urandom, $urandom, $urandom};
    e_valid = model(8'h00, '0, r_msg, 8'h00);
    frame_and_check("nokey_msg", 8'h00, '0, r_msg, 8'h00, 1, e_valid, 1'b0, 1'b0, exp_msg, exp_key, exp_kl);

    // Random frames against the reference model.
    for (int n = 0; n < 40; n++) begin
      kind  = $urandom_range(3, 0);
      r_msg = {$urandom, $urandom, $urandom, $urandom};
      r_key = {$urandom, $urandom, $urandom, $urandom};
      r_typ = (kind == 0) ? 8'h00 : (kind == 3) ? 8'($urandom_range(255, 2)) : 8'h01;
      r_cx  = (kind == 2) ? 8'($urandom_range(255, 1)) : 8'h00;
      for (int j = 0; j < int'($urandom_range(3, 0)); j++) begin
        junk = 8'($urandom_range(255, 0));
        if (junk == HDR) junk = 8'h00;
        send_byte(junk);
      end
      hold_n = $urandom_range(1, 0) ? 0 : $urandom_range(4, 1);
      if (hold_n != 0) bi.out_ready = 1'b0;
      e_valid = model(r_typ, r_key, r_msg, r_cx);
      frame_and_check($sformatf("rnd%0d", n), r_typ, r_key, r_msg, r_cx, 3, e_valid,
                      kind == 2, kind == 3, exp_msg, exp_key, exp_kl);
      if (hold_n != 0) begin
        for (int j = 0; j < int'(hold_n); j++) begin
          @(negedge clk);
          check("rnd.hold_valid", bi.out_valid, e_valid);
        end
        bi.out_ready = 1'b1;
        @(negedge clk);
        check("rnd.release_valid", bi.out_valid, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
